// File: rtl/multicycle_proc.sv
// multicycle_proc: RV32I-subset core stepping through IF, ID, EX, MEM and WB,
// one clock per state, so every instruction takes exactly five cycles.
// Instruction and data memories are external; outputs come straight from flops.
module multicycle_proc #(
  parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] dReadData,
  output logic [31:0] PC,
  output logic [31:0] dAddress,
  output logic [31:0] dWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] WriteBackData
);

  typedef enum logic [2:0] {S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4} state_t;
  typedef enum logic [2:0] {K_NOP = 3'd0, K_ALU = 3'd1, K_LW = 3'd2, K_SW = 3'd3, K_BEQ = 3'd4} kind_t;
  typedef enum logic [3:0] {A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4,
                            A_SLT = 4'd5, A_SLL = 4'd6, A_SRL = 4'd7, A_SRA = 4'd8} alu_op_t;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  alu_op_t     alu_op_q, alu_op_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] pc_q, pc_d, opa_q, opa_d, opb_q, opb_d, rs2v_q, rs2v_d;
  logic [31:0] immb_q, immb_d, alu_q, alu_d, wbd_q, wbd_d;
  logic        zero_q, zero_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  logic [6:0]  funct7_s;
  logic [2:0]  funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, rs1v_s, rs2v_s, dec_b_s, alu_s, wb_s;
  kind_t       dec_kind_s;
  alu_op_t     dec_op_s;

  // Decode the fetched word: operand reads, immediates and the operation class.
  always_comb begin
    funct7_s   = instr[31:25];
    funct3_s   = instr[14:12];
    imm_i_s    = {{20{instr[31]}}, instr[31:20]};
    imm_s_s    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b_s    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    rs1v_s     = regs_q[instr[19:15]];
    rs2v_s     = regs_q[instr[24:20]];
    dec_kind_s = K_NOP;
    dec_op_s   = A_ADD;
    dec_b_s    = imm_i_s;
    case (instr[6:0])
      OP_R: begin
        dec_b_s = rs2v_s;
        if (funct7_s == 7'b0000000) begin
          dec_kind_s = K_ALU;
          case (funct3_s)
            3'b000:  dec_op_s = A_ADD;
            3'b001:  dec_op_s = A_SLL;
            3'b010:  dec_op_s = A_SLT;
            3'b100:  dec_op_s = A_XOR;
            3'b101:  dec_op_s = A_SRL;
            3'b110:  dec_op_s = A_OR;
            3'b111:  dec_op_s = A_AND;
            default: dec_kind_s = K_NOP;
          endcase
        end else if (funct7_s == 7'b0100000) begin
          dec_kind_s = K_ALU;
          case (funct3_s)
            3'b000:  dec_op_s = A_SUB;
            3'b101:  dec_op_s = A_SRA;
            default: dec_kind_s = K_NOP;
          endcase
        end else begin
          dec_kind_s = K_NOP;
        end
      end
      OP_I: begin
        dec_kind_s = K_ALU;
        case (funct3_s)
          3'b000: dec_op_s = A_ADD;
          3'b010: dec_op_s = A_SLT;
          3'b100: dec_op_s = A_XOR;
          3'b110: dec_op_s = A_OR;
          3'b111: dec_op_s = A_AND;
          3'b001: begin
            if (funct7_s == 7'b0000000) dec_op_s = A_SLL;
            else dec_kind_s = K_NOP;
          end
          3'b101: begin
            if (funct7_s == 7'b0000000) dec_op_s = A_SRL;
            else if (funct7_s == 7'b0100000) dec_op_s = A_SRA;
            else dec_kind_s = K_NOP;
          end
          default: dec_kind_s = K_NOP;
        endcase
      end
      OP_LW: begin
        if (funct3_s == 3'b010) dec_kind_s = K_LW;
        else dec_kind_s = K_NOP;
      end
      OP_SW: begin
        dec_b_s = imm_s_s;
        if (funct3_s == 3'b010) dec_kind_s = K_SW;
        else dec_kind_s = K_NOP;
      end
      OP_BR: begin
        dec_b_s = rs2v_s;
        if (funct3_s == 3'b000) dec_kind_s = K_BEQ;
        else dec_kind_s = K_NOP;
      end
      default: dec_kind_s = K_NOP;
    endcase
  end

  // ALU on the operands latched at the end of ID; shifts use the low 5 bits.
  always_comb begin
    case (alu_op_q)
      A_ADD:   alu_s = opa_q + opb_q;
      A_SUB:   alu_s = opa_q - opb_q;
      A_AND:   alu_s = opa_q & opb_q;
      A_OR:    alu_s = opa_q | opb_q;
      A_XOR:   alu_s = opa_q ^ opb_q;
      A_SLT:   alu_s = {31'd0, ($signed(opa_q) < $signed(opb_q))};
      A_SLL:   alu_s = opa_q << opb_q[4:0];
      A_SRL:   alu_s = opa_q >> opb_q[4:0];
      A_SRA:   alu_s = $unsigned($signed(opa_q) >>> opb_q[4:0]);
      default: alu_s = 32'd0;
    endcase
    if (kind_q == K_LW) wb_s = dReadData;
    else wb_s = alu_q;
  end

  // FSM state register; reset parks the machine in IF.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IF;
    else state_q <= state_d;
  end

  // Fixed IF -> ID -> EX -> MEM -> WB ring.
  always_comb begin
    case (state_q)
      S_IF:    state_d = S_ID;
      S_ID:    state_d = S_EX;
      S_EX:    state_d = S_MEM;
      S_MEM:   state_d = S_WB;
      S_WB:    state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  // Per-state datapath updates; all architectural effects land on the WB edge.
  always_comb begin
    pc_d = pc_q;       kind_d = kind_q;   alu_op_d = alu_op_q; rd_d = rd_q;
    opa_d = opa_q;     opb_d = opb_q;     rs2v_d = rs2v_q;     immb_d = immb_q;
    alu_d = alu_q;     wbd_d = wbd_q;     zero_d = zero_q;
    mem_read_d = mem_read_q;              mem_write_d = mem_write_q;
    regs_d = regs_q;
    case (state_q)
      S_IF: pc_d = pc_q;
      S_ID: begin
        kind_d = dec_kind_s; alu_op_d = dec_op_s; rd_d = instr[11:7];
        opa_d = rs1v_s; opb_d = dec_b_s; rs2v_d = rs2v_s; immb_d = imm_b_s;
      end
      S_EX: begin
        alu_d       = alu_s;
        zero_d      = ((opa_q - rs2v_q) == 32'd0);
        mem_read_d  = (kind_q == K_LW);
        mem_write_d = (kind_q == K_SW);
      end
      S_MEM: begin
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
      S_WB: begin
        if ((kind_q == K_ALU) || (kind_q == K_LW)) begin
          wbd_d = wb_s;
          regs_d[rd_q] = wb_s;
        end else begin
          wbd_d = wbd_q;
        end
        if ((kind_q == K_BEQ) && zero_q) pc_d = pc_q + immb_q;
        else pc_d = pc_q + 32'd4;
      end
      default: pc_d = pc_q;
    endcase
    regs_d[0] = 32'd0;
  end

  // Datapath and register-file flops; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= INITIAL_PC; kind_q <= K_NOP; alu_op_q <= A_ADD; rd_q <= 5'd0;
      opa_q <= 32'd0; opb_q <= 32'd0; rs2v_q <= 32'd0; immb_q <= 32'd0;
      alu_q <= 32'd0; wbd_q <= 32'd0; zero_q <= 1'b0;
      mem_read_q <= 1'b0; mem_write_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d; kind_q <= kind_d; alu_op_q <= alu_op_d; rd_q <= rd_d;
      opa_q <= opa_d; opb_q <= opb_d; rs2v_q <= rs2v_d; immb_q <= immb_d;
      alu_q <= alu_d; wbd_q <= wbd_d; zero_q <= zero_d;
      mem_read_q <= mem_read_d; mem_write_q <= mem_write_d;
      regs_q <= regs_d;
    end
  end

  assign PC            = pc_q;
  assign dAddress      = alu_q;
  assign dWriteData    = rs2v_q;
  assign MemRead       = mem_read_q;
  assign MemWrite      = mem_write_q;
  assign WriteBackData = wbd_q;

endmodule

// File: tb/tb_multicycle_proc.sv
// tb_multicycle_proc: directed and random RV32I-subset programs checked
// against an instruction-level reference model and a word-array data memory.
module tb_multicycle_proc;

  localparam logic [31:0] INIT_PC = 32'h00400000;

  logic        clk, rst;
  logic [31:0] instr, dReadData;
  logic [31:0] PC, dAddress, dWriteData, WriteBackData;
  logic        MemRead, MemWrite;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [128];
  logic [31:0] m_pc;

  multicycle_proc dut (
    .clk(clk), .rst(rst), .instr(instr), .dReadData(dReadData),
    .PC(PC), .dAddress(dAddress), .dWriteData(dWriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .WriteBackData(WriteBackData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // Reference ALU: signed compare by bias flip, arithmetic shift by fill mask.
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << s;
      3'd2: return ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? ((a >> s) | (a[31] ? ~(32'hFFFFFFFF >> s) : 32'd0)) : (a >> s);
      3'd6: return a | b;
      3'd7: return a & b;
      default: return 32'd0;
    endcase
  endfunction

  // Execute one instruction through its five cycles, checking against the model.
  // Entered and left at a falling edge inside IF.
  task automatic exec(input logic [31:0] w);
    logic [31:0] r1, r2, immi, imms, immb, res, addr, npc, wbv;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    int kind; // 0 nop, 1 alu, 2 lw, 3 sw, 4 beq
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; rd = w[11:7];
    r1 = m_regs[w[19:15]]; r2 = m_regs[w[24:20]];
    immi = {{20{w[31]}}, w[31:20]};
    imms = {{20{w[31]}}, w[31:25], w[11:7]};
    immb = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    kind = 0; res = 32'd0;
    case (opc)
      7'b0110011: begin
        if (f7 == 7'h00 && f3 != 3'd3) begin kind = 1; res = ref_alu(f3, 1'b0, r1, r2); end
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin kind = 1; res = ref_alu(f3, 1'b1, r1, r2); end
      end
      7'b0010011: begin
        if (f3 == 3'd1) kind = (f7 == 7'h00) ? 1 : 0;
        else if (f3 == 3'd5) kind = (f7 == 7'h00 || f7 == 7'h20) ? 1 : 0;
        else if (f3 != 3'd3) kind = 1;
        res = ref_alu(f3, (f3 == 3'd5) && (f7 == 7'h20), r1, immi);
      end
      7'b0000011: if (f3 == 3'd2) kind = 2;
      7'b0100011: if (f3 == 3'd2) kind = 3;
      7'b1100011: if (f3 == 3'd0) kind = 4;
      default: kind = 0;
    endcase
    addr = r1 + ((kind == 3) ? imms : immi);
    npc  = (kind == 4 && r1 == r2) ? m_pc + immb : m_pc + 32'd4;

    instr = w;
    check_eq("pc_if", PC, m_pc);
    @(posedge clk); @(negedge clk); // ID
    check_eq("memctl_id", {30'd0, MemRead, MemWrite}, 32'd0);
    check_eq("pc_id", PC, m_pc);
    @(posedge clk); @(negedge clk); // EX
    @(posedge clk); @(negedge clk); // MEM
    check_eq("memread", {31'd0, MemRead}, {31'd0, (kind == 2)});
    check_eq("memwrite", {31'd0, MemWrite}, {31'd0, (kind == 3)});
    if (kind == 2 || kind == 3) check_eq("daddr", dAddress, addr);
    if (kind == 3) begin
      check_eq("dwdata", dWriteData, r2);
      m_mem[addr[8:2]] = r2;
    end
    @(posedge clk); @(negedge clk); // WB
    check_eq("memctl_wb", {30'd0, MemRead, MemWrite}, 32'd0);
    check_eq("pc_wb", PC, m_pc);
    dReadData = (kind == 2) ? m_mem[addr[8:2]] : $urandom();
    wbv = (kind == 2) ? dReadData : res;
    @(posedge clk); @(negedge clk); // next IF
    if ((kind == 1 || kind == 2) && rd != 5'd0) begin
      m_regs[rd] = wbv;
      check_eq("wbdata", WriteBackData, wbv);
    end
    m_pc = npc;
    check_eq("pc_next", PC, m_pc);
  endtask

  // Run an SW up to its MEM state, then assert reset before the write edge.
  task automatic sw_reset_in_mem(input logic [31:0] w);
    instr = w;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check_eq("rst_sw_memwrite_pre", {31'd0, MemWrite}, 32'd1);
    rst = 1'b0;
    #1;
    check_eq("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check_eq("rst_memread", {31'd0, MemRead}, 32'd0);
    check_eq("rst_pc", PC, INIT_PC);
    check_eq("rst_wbdata", WriteBackData, 32'd0);
    @(posedge clk); @(negedge clk);
    check_eq("rst_hold_memwrite", {31'd0, MemWrite}, 32'd0);
    rst = 1'b1;
    m_pc = INIT_PC;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endtask

  function automatic logic [31:0] gen_rand();
    logic [31:0] t;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    t = $urandom();
    rd = 5'($urandom_range(0, 15)); rs1 = 5'($urandom_range(0, 15)); rs2 = 5'($urandom_range(0, 15));
    case ($urandom_range(0, 11))
      0, 1, 2: begin
        f3 = 3'($urandom_range(0, 7));
        return enc_r(((f3 == 3'd0 || f3 == 3'd5) && t[0]) ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
      end
      3, 4, 9: begin
        case ($urandom_range(0, 4))
          0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd4; 3: f3 = 3'd6; default: f3 = 3'd7;
        endcase
        return enc_i(t[11:0], rs1, f3, rd, 7'b0010011);
      end
      5: begin
        f3 = t[20] ? 3'd5 : 3'd1;
        return enc_i({(f3 == 3'd5 && t[21]) ? 7'h20 : 7'h00, t[4:0]}, rs1, f3, rd, 7'b0010011);
      end
      6: return enc_i(t[11:0], rs1, 3'd2, rd, 7'b0000011);
      7: return enc_s(t[11:0], rs2, rs1);
      8: return enc_b({t[12:1], 1'b0}, t[13] ? rs1 : rs2, rs1);
      10: return {t[31:7], 7'b1101111};
      default: begin
        case (t[1:0])
          2'd0: return enc_r(7'h01, rs2, rs1, 3'd0, rd);
          2'd1: return enc_r(7'h00, rs2, rs1, 3'd3, rd);
          2'd2: return enc_i(t[31:20], rs1, 3'd0, rd, 7'b0000011);
          default: return {t[31:15], 3'd1, t[11:7], 7'b1100011};
        endcase
      end
    endcase
  endfunction

  initial begin
    logic [31:0] pc0;
    rst = 1'b0; instr = 32'h00000013; dReadData = 32'd0;
    m_pc = INIT_PC;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    for (int i = 0; i < 128; i++) m_mem[i] = $urandom();
    repeat (3) @(negedge clk);
    check_eq("reset_pc", PC, INIT_PC);
    check_eq("reset_memctl", {30'd0, MemRead, MemWrite}, 32'd0);
    check_eq("reset_wbdata", WriteBackData, 32'd0);
    rst = 1'b1;

    exec(32'h00000013);
    check_eq("nop_pc", PC, 32'h00400004);

    exec(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'b0010011));
    check_eq("addi_5", WriteBackData, 32'd5);
    exec(enc_i(12'hFFD, 5'd0, 3'd0, 5'd2, 7'b0010011));
    check_eq("addi_m3", WriteBackData, 32'hFFFFFFFD);
    exec(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    check_eq("add_2", WriteBackData, 32'd2);

    exec(enc_s(12'd8, 5'd1, 5'd0));
    exec(enc_i(12'd8, 5'd0, 3'd2, 5'd4, 7'b0000011));
    check_eq("lw_x4", WriteBackData, 32'd5);
    exec(enc_s(12'd16, 5'd4, 5'd0));
    check_eq("probe_x4", dWriteData, 32'd5);

    pc0 = PC;
    exec(enc_b(13'd8, 5'd1, 5'd1));
    check_eq("beq_taken", PC, pc0 + 32'd8);
    pc0 = PC;
    exec(enc_b(13'd8, 5'd2, 5'd1));
    check_eq("beq_not_taken", PC, pc0 + 32'd4);

    exec(enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5));
    check_eq("slt_signed", WriteBackData, 32'd1);
    exec(enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'b0010011));
    exec(enc_i(12'd31, 5'd6, 3'd1, 5'd6, 7'b0010011));
    check_eq("slli_31", WriteBackData, 32'h80000000);
    exec(enc_i(12'd4, 5'd0, 3'd0, 5'd7, 7'b0010011));
    exec(enc_r(7'h20, 5'd7, 5'd6, 3'd5, 5'd8));
    check_eq("sra_4", WriteBackData, 32'hF8000000);
    exec(enc_r(7'h00, 5'd7, 5'd6, 3'd5, 5'd9));
    check_eq("srl_4", WriteBackData, 32'h08000000);
    exec(enc_i(12'h404, 5'd6, 3'd5, 5'd10, 7'b0010011));
    check_eq("srai_4", WriteBackData, 32'hF8000000);

    exec(enc_i(12'd7, 5'd0, 3'd0, 5'd0, 7'b0010011));
    exec(enc_s(12'd20, 5'd0, 5'd0));
    check_eq("x0_zero", dWriteData, 32'd0);

    sw_reset_in_mem(enc_s(12'd12, 5'd3, 5'd0));
    exec(enc_i(12'd12, 5'd0, 3'd2, 5'd11, 7'b0000011));
    exec(enc_s(12'd24, 5'd1, 5'd0));
    check_eq("after_rst_x1", dWriteData, 32'd0);

    for (int n = 0; n < 200; n++) exec(gen_rand());
    for (int r = 1; r < 16; r++) exec(enc_s(12'(r * 4), 5'(r), 5'd0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
